// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and types used by the SEQ decode/writeback stage.
package y86_pkg;

   typedef logic [3:0]  icode_t;
   typedef logic [3:0]  regid_t;
   typedef logic [63:0] word_t;

   localparam icode_t I_HALT  = 4'h0;
   localparam icode_t I_NOP   = 4'h1;
   localparam icode_t I_CMOV  = 4'h2;
   localparam icode_t I_IRMOV = 4'h3;
   localparam icode_t I_RMMOV = 4'h4;
   localparam icode_t I_MRMOV = 4'h5;
   localparam icode_t I_OPQ   = 4'h6;
   localparam icode_t I_JXX   = 4'h7;
   localparam icode_t I_CALL  = 4'h8;
   localparam icode_t I_RET   = 4'h9;
   localparam icode_t I_PUSH  = 4'hA;
   localparam icode_t I_POP   = 4'hB;

   localparam regid_t R_RSP  = 4'h4;
   localparam regid_t R_NONE = 4'hF;

endpackage

// File: rtl/regfile_2r2w.sv
// Register file: two async read ports plus a debug port, two sync write ports
// (port M overrides port E on the same ID), async active-high clear.
module regfile_2r2w
   import y86_pkg::*;
#(
   parameter int NREG = 15
) (
   input  logic   clk,
   input  logic   rst,
   input  regid_t ra_a,
   input  regid_t ra_b,
   input  regid_t ra_dbg,
   input  logic   we,
   input  regid_t wa_e,
   input  word_t  wd_e,
   input  regid_t wa_m,
   input  word_t  wd_m,
   output word_t  rd_a,
   output word_t  rd_b,
   output word_t  rd_dbg
);

   word_t regs_q [NREG];
   word_t regs_d [NREG];

   // ID R_NONE matches no entry, so it is never written and reads as 0.
   always_comb begin
      regs_d = regs_q;
      if (we) begin
         for (int i = 0; i < NREG; i++) begin
            if (wa_e == regid_t'(i)) regs_d[i] = wd_e;
            if (wa_m == regid_t'(i)) regs_d[i] = wd_m;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rd_a   = '0;
      rd_b   = '0;
      rd_dbg = '0;
      for (int i = 0; i < NREG; i++) begin
         if (ra_a   == regid_t'(i)) rd_a   = regs_q[i];
         if (ra_b   == regid_t'(i)) rd_b   = regs_q[i];
         if (ra_dbg == regid_t'(i)) rd_dbg = regs_q[i];
      end
   end

endmodule

// File: rtl/decode_writeback.sv
// SEQ Y86-64 decode/writeback: derives srcA/srcB/dstE/dstM from icode and
// register specifiers, reads operands and commits valE/valM at the clock edge.
module decode_writeback
   import y86_pkg::*;
#(
   parameter int NREG   = 15,
   parameter int RSP_ID = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  icode,
   input  logic [3:0]  rA,
   input  logic [3:0]  rB,
   input  logic        cnd,
   input  logic [63:0] valE,
   input  logic [63:0] valM,
   input  logic        wb_en,
   input  logic [3:0]  dbg_sel,
   output logic [3:0]  srcA,
   output logic [3:0]  srcB,
   output logic [3:0]  dstE,
   output logic [3:0]  dstM,
   output logic [63:0] valA,
   output logic [63:0] valB,
   output logic [63:0] dbg_val
);

   localparam regid_t RSP = regid_t'(RSP_ID);

   always_comb begin
      srcA = R_NONE;
      srcB = R_NONE;
      dstE = R_NONE;
      dstM = R_NONE;
      case (icode)
         I_CMOV: begin
            srcA = rA;
            dstE = cnd ? rB : R_NONE;
         end
         I_IRMOV: dstE = rB;
         I_RMMOV: begin
            srcA = rA;
            srcB = rB;
         end
         I_MRMOV: begin
            srcB = rB;
            dstM = rA;
         end
         I_OPQ: begin
            srcA = rA;
            srcB = rB;
            dstE = rB;
         end
         I_CALL: begin
            srcB = RSP;
            dstE = RSP;
         end
         I_RET: begin
            srcA = RSP;
            srcB = RSP;
            dstE = RSP;
         end
         I_PUSH: begin
            srcA = rA;
            srcB = RSP;
            dstE = RSP;
         end
         I_POP: begin
            srcA = RSP;
            srcB = RSP;
            dstE = RSP;
            dstM = rA;
         end
         default: ;
      endcase
   end

   regfile_2r2w #(.NREG(NREG)) u_rf (
      .clk    (clk),
      .rst    (rst),
      .ra_a   (srcA),
      .ra_b   (srcB),
      .ra_dbg (dbg_sel),
      .we     (wb_en),
      .wa_e   (dstE),
      .wd_e   (valE),
      .wa_m   (dstM),
      .wd_m   (valM),
      .rd_a   (valA),
      .rd_b   (valB),
      .rd_dbg (dbg_val)
   );

endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback: expected values are queued as stimulus
// is applied and popped when the corresponding output is sampled.
module tb_decode_writeback;

   logic        clk;
   logic        rst;
   logic [3:0]  icode;
   logic [3:0]  rA;
   logic [3:0]  rB;
   logic        cnd;
   logic [63:0] valE;
   logic [63:0] valM;
   logic        wb_en;
   logic [3:0]  dbg_sel;
   logic [3:0]  srcA;
   logic [3:0]  srcB;
   logic [3:0]  dstE;
   logic [3:0]  dstM;
   logic [63:0] valA;
   logic [63:0] valB;
   logic [63:0] dbg_val;

   logic [63:0] exp_q[$];
   logic [63:0] model [15];
   int n_checks;
   int n_pass;

   decode_writeback #(.NREG(15), .RSP_ID(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .icode   (icode),
      .rA      (rA),
      .rB      (rB),
      .cnd     (cnd),
      .valE    (valE),
      .valM    (valM),
      .wb_en   (wb_en),
      .dbg_sel (dbg_sel),
      .srcA    (srcA),
      .srcB    (srcB),
      .dstE    (dstE),
      .dstM    (dstM),
      .valA    (valA),
      .valB    (valB),
      .dbg_val (dbg_val)
   );

   // clock / reset
   initial clk = 1'b0;
   always #50 clk = ~clk;

   // driver tasks
   task automatic push_exp(input logic [63:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [63:0] obs);
      logic [63:0] exp_v;
      if (exp_q.size() == 0) begin
         n_checks++;
         $error("FAIL %s: observed %h but expected queue is empty", tag, obs);
      end else begin
         exp_v = exp_q.pop_front();
         n_checks++;
         assert (obs === exp_v) n_pass++;
         else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic exp_check(input string tag, input logic [63:0] obs, input logic [63:0] v);
      push_exp(v);
      check(tag, obs);
   endtask

   task automatic clk_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic [63:0] e, input logic [63:0] m,
                        input logic we);
      icode = ic;
      rA    = a;
      rB    = b;
      cnd   = c;
      valE  = e;
      valM  = m;
      wb_en = we;
      #1;
   endtask

   task automatic peek(input logic [3:0] id, input string tag, input logic [63:0] v);
      dbg_sel = id;
      #1;
      exp_check(tag, dbg_val, v);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      dbg_sel  = 4'd0;
      for (int i = 0; i < 15; i++) model[i] = 64'd0;
      drive(4'h6, 4'd1, 4'd2, 1'b0, 64'd0, 64'd0, 1'b0);
      #20;
      exp_check("reset_valA", valA, 64'd0);
      exp_check("reset_valB", valB, 64'd0);
      peek(4'd7, "reset_dbg7", 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // 1. fill the file with random values, then clear it asynchronously
      for (int i = 0; i < 15; i++) begin
         model[i] = {$urandom, $urandom} | 64'd1;
         drive(4'h3, 4'hF, 4'(i), 1'b0, model[i], 64'd0, 1'b1);
         clk_edge();
      end
      wb_en = 1'b0;
      for (int i = 0; i < 15; i++) peek(4'(i), "fill_dbg", model[i]);
      @(negedge clk);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 15; i++) peek(4'(i), "async_clear_dbg", 64'd0);
      for (int i = 0; i < 15; i++) model[i] = 64'd0;
      drive(4'h3, 4'hF, 4'd6, 1'b0, 64'h99, 64'd0, 1'b1);
      clk_edge();
      peek(4'd6, "write_during_rst", 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // 2. irmovq 0x1234,%rbx then OPq %rbx,%rcx
      drive(4'h3, 4'hF, 4'd3, 1'b0, 64'h1234, 64'd0, 1'b1);
      exp_check("irmov_dstE", 64'(dstE), 64'd3);
      exp_check("irmov_srcA", 64'(srcA), 64'd15);
      clk_edge();
      drive(4'h6, 4'd3, 4'd1, 1'b0, 64'd0, 64'd0, 1'b0);
      exp_check("opq_srcA", 64'(srcA), 64'd3);
      exp_check("opq_srcB", 64'(srcB), 64'd1);
      exp_check("opq_dstE", 64'(dstE), 64'd1);
      exp_check("opq_valA", valA, 64'h1234);
      exp_check("opq_valB", valB, 64'd0);

      // 3. cmov qualification
      drive(4'h2, 4'd3, 4'd5, 1'b0, 64'hAA, 64'd0, 1'b1);
      exp_check("cmov_nc_dstE", 64'(dstE), 64'd15);
      exp_check("cmov_nc_srcA", 64'(srcA), 64'd3);
      exp_check("cmov_nc_srcB", 64'(srcB), 64'd15);
      exp_check("cmov_nc_dstM", 64'(dstM), 64'd15);
      clk_edge();
      peek(4'd5, "cmov_nc_reg5", 64'd0);
      drive(4'h2, 4'd3, 4'd5, 1'b1, 64'hAA, 64'd0, 1'b1);
      exp_check("cmov_c_dstE", 64'(dstE), 64'd5);
      clk_edge();
      peek(4'd5, "cmov_c_reg5", 64'hAA);

      // 4. popq %rsp: valM beats valE
      drive(4'hB, 4'd4, 4'hF, 1'b0, 64'h100, 64'hDEAD, 1'b1);
      exp_check("pop_srcA", 64'(srcA), 64'd4);
      exp_check("pop_srcB", 64'(srcB), 64'd4);
      exp_check("pop_dstE", 64'(dstE), 64'd4);
      exp_check("pop_dstM", 64'(dstM), 64'd4);
      clk_edge();
      peek(4'd4, "pop_reg4", 64'hDEAD);

      // 5. call/ret stack IDs and undefined icode
      drive(4'h8, 4'd3, 4'd5, 1'b0, 64'd0, 64'd0, 1'b0);
      exp_check("call_srcA", 64'(srcA), 64'd15);
      exp_check("call_srcB", 64'(srcB), 64'd4);
      exp_check("call_dstE", 64'(dstE), 64'd4);
      exp_check("call_dstM", 64'(dstM), 64'd15);
      drive(4'h9, 4'd3, 4'd5, 1'b0, 64'd0, 64'd0, 1'b0);
      exp_check("ret_srcA", 64'(srcA), 64'd4);
      exp_check("ret_srcB", 64'(srcB), 64'd4);
      exp_check("ret_dstE", 64'(dstE), 64'd4);
      exp_check("ret_dstM", 64'(dstM), 64'd15);
      exp_check("ret_valA", valA, 64'hDEAD);
      drive(4'hC, 4'd3, 4'd5, 1'b1, 64'd0, 64'd0, 1'b0);
      exp_check("bad_srcA", 64'(srcA), 64'd15);
      exp_check("bad_srcB", 64'(srcB), 64'd15);
      exp_check("bad_dstE", 64'(dstE), 64'd15);
      exp_check("bad_dstM", 64'(dstM), 64'd15);
      exp_check("bad_valA", valA, 64'd0);
      exp_check("bad_valB", valB, 64'd0);

      // 6. write gating and no same-cycle bypass
      drive(4'h3, 4'hF, 4'd2, 1'b0, 64'h55, 64'd0, 1'b0);
      clk_edge();
      peek(4'd2, "gated_reg2", 64'd0);
      drive(4'h3, 4'hF, 4'd2, 1'b0, 64'h77, 64'd0, 1'b1);
      clk_edge();
      drive(4'h6, 4'd2, 4'd2, 1'b0, 64'h55, 64'd0, 1'b1);
      exp_check("nobyp_srcA", 64'(srcA), 64'd2);
      exp_check("nobyp_before", valA, 64'h77);
      clk_edge();
      wb_en = 1'b0;
      #1;
      exp_check("nobyp_after", valA, 64'h55);
      peek(4'd3, "final_reg3", 64'h1234);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
